// File: rtl/coin_serializer_pkg.sv
// -----------------------------------------------------------------------------
// coin_serializer_pkg
// Shared definitions for the serial coin interface:
//   - coin type codes (penny/nickel/dime/quarter)
//   - base 10-bit coin codes; the emitted code is base + offset (0..9)
//   - word width and receiver accept window
//   - serializer FSM state encoding
//   - coin_base(): type -> base code lookup
// -----------------------------------------------------------------------------
package coin_serializer_pkg;

    localparam int COIN_WORD_W = 10;
    localparam int COIN_WINDOW = 10;

    localparam logic [1:0] COIN_PENNY   = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    localparam logic [COIN_WORD_W-1:0] PENNY_BASE   = 10'd745;
    localparam logic [COIN_WORD_W-1:0] NICKEL_BASE  = 10'd830;
    localparam logic [COIN_WORD_W-1:0] DIME_BASE    = 10'd700;
    localparam logic [COIN_WORD_W-1:0] QUARTER_BASE = 10'd950;

    // Offset used when jitter is not compiled in.
    localparam logic [3:0] FIXED_OFFSET = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [COIN_WORD_W-1:0] coin_base(input logic [1:0] t);
        logic [COIN_WORD_W-1:0] b;
        case (t)
            COIN_PENNY:  b = PENNY_BASE;
            COIN_NICKEL: b = NICKEL_BASE;
            COIN_DIME:   b = DIME_BASE;
            default:     b = QUARTER_BASE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/coin_serializer_fifo.sv
// -----------------------------------------------------------------------------
// coin_serializer_fifo
// Synchronous FIFO holding pending coin requests (coin_type only; the code is
// computed when the entry is popped).
//   i_clk, i_reset      clock, synchronous active-high reset (flushes)
//   i_push, i_din       write strobe and data
//   i_pop, o_dout       read strobe; o_dout shows the head entry
//   o_full, o_empty     status
//   o_count             number of entries held (0..DEPTH)
// Push and pop in the same cycle are legal at any fill level; the caller
// never pushes when full nor pops when empty.
// -----------------------------------------------------------------------------
module coin_serializer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/coin_serializer.sv
// -----------------------------------------------------------------------------
// coin_serializer
// Transmit side of the serial coin interface. Coin requests are accepted with
// a valid/ready handshake, queued, and each is sent as one 10-bit code, MSB
// first, one bit per clock with enable high for exactly 10 cycles.
//   clk, reset     clock, synchronous active-high reset
//   coin_valid     request to insert a coin
//   coin_type      0 penny, 1 nickel, 2 dime, 3 quarter
//   coin_ready     queue can accept
//   serialOut      serial bit (0 whenever enable is low)
//   enable         high while serialOut carries a valid bit
//   busy           queue non-empty or a word/gap in progress
//   coins_sent     fully transmitted words, wraps modulo 256
//   dbg_state      current FSM state (state_t encoding)
// Handshake: a request transfers on a rising edge where coin_valid and
// coin_ready are both high; coin_ready depends only on queue fullness.
// Optional macro CODE_JITTER_EN: code offset comes from a 16-bit LFSR mod 10
// instead of the fixed offset 4.
// -----------------------------------------------------------------------------
module coin_serializer
    import coin_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 10,   // protocol width; only 10 is supported
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    output logic       serialOut,
    output logic       enable,
    output logic       busy,
    output logic [7:0] coins_sent,
    output logic [1:0] dbg_state
);
    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t              r_state;
    state_t              w_next;
    logic [WORD_W-1:0]   r_shift;
    logic [3:0]          r_cnt;
    logic [7:0]          r_gap_cnt;
    logic                r_enable;
    logic [7:0]          r_coins;

    logic                w_push;
    logic                w_load;
    logic                w_done;
    logic                w_full;
    logic                w_empty;
    logic [1:0]          w_head_type;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [3:0]          w_offset;
    logic [WORD_W-1:0]   w_code;

    assign w_push = coin_valid && !w_full;

    coin_serializer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_din   (coin_type),
        .i_pop   (w_load),
        .o_dout  (w_head_type),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef CODE_JITTER_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running every clock.
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_offset = 4'(r_lfsr % 16'd10);
`else
    assign w_offset = FIXED_OFFSET;
`endif

    // Code is formed from the head entry at the moment it is popped.
    assign w_code = WORD_W'(coin_base(w_head_type) + 10'(w_offset));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and control strobes. A finished gap pops directly when work
    // is waiting, so enable is low for exactly GAP_CYCLES between queued words.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_done = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_next = ST_GAP;
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                        w_next = ST_SHIFT;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (!w_empty) begin
                        w_load = 1'b1;
                        w_next = ST_SHIFT;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Registered datapath outputs. r_shift is cleared whenever no word is in
    // flight so its MSB can drive serialOut directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_enable  <= 1'b0;
            r_coins   <= '0;
        end else begin
            if (w_load) begin
                r_shift  <= w_code;
                r_cnt    <= '0;
                r_enable <= 1'b1;
            end else if (w_done) begin
                r_shift  <= '0;
                r_enable <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt + 1'b1;
            end

            if (w_done) r_coins <= r_coins + 8'd1;

            if (w_done)                  r_gap_cnt <= '0;
            else if (r_state == ST_GAP)  r_gap_cnt <= r_gap_cnt + 8'd1;
        end
    end

    assign coin_ready = !w_full;
    assign serialOut  = r_shift[WORD_W-1];
    assign enable     = r_enable;
    assign coins_sent = r_coins;
    assign busy       = (w_count != '0) || (r_state != ST_IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_coin_serializer.sv
// -----------------------------------------------------------------------------
// tb_coin_serializer
// Two instances: dut_a with GAP_CYCLES=1, dut_b with GAP_CYCLES=0. Each has a
// monitor that deserialises enable-qualified bits and compares every word
// against an expected-code queue filled when a request is accepted.
// -----------------------------------------------------------------------------
module tb_coin_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0] a_type = 2'd0, b_type = 2'd0;
    logic       a_ready, a_serial, a_enable, a_busy;
    logic       b_ready, b_serial, b_enable, b_busy;
    logic [7:0] a_coins, b_coins;
    logic [1:0] a_state, b_state;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    always #5 clk = ~clk;

    coin_serializer #(.FIFO_DEPTH(4), .WORD_W(10), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .coin_valid(a_valid), .coin_type(a_type),
        .coin_ready(a_ready), .serialOut(a_serial), .enable(a_enable),
        .busy(a_busy), .coins_sent(a_coins), .dbg_state(a_state)
    );

    coin_serializer #(.FIFO_DEPTH(4), .WORD_W(10), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .coin_valid(b_valid), .coin_type(b_type),
        .coin_ready(b_ready), .serialOut(b_serial), .enable(b_enable),
        .busy(b_busy), .coins_sent(b_coins), .dbg_state(b_state)
    );

    // Expected code for a coin type. With jitter, the base is stored and the
    // received word must fall in base..base+9.
    function automatic logic [9:0] exp_code(input logic [1:0] t);
`ifdef CODE_JITTER_EN
        case (t)
            2'd0: return 10'd745;
            2'd1: return 10'd830;
            2'd2: return 10'd700;
            default: return 10'd950;
        endcase
`else
        case (t)
            2'd0: return 10'd749;
            2'd1: return 10'd834;
            2'd2: return 10'd704;
            default: return 10'd954;
        endcase
`endif
    endfunction

    function automatic bit word_ok(input logic [9:0] got, input logic [9:0] e);
`ifdef CODE_JITTER_EN
        return (got >= e) && (got <= e + 10'd9);
`else
        return got === e;
`endif
    endfunction

    // ---------------- monitors ----------------
    int         a_bits = 0, a_run = 0;
    logic [9:0] a_word = '0;
    int         b_bits = 0;
    logic [9:0] b_word = '0;

    always @(negedge clk) begin
        if (reset) begin
            a_bits = 0;
            a_run  = 0;
        end else if (!a_enable) begin
            vectors++;
            if (a_serial !== 1'b0) begin
                miscompares++;
                $display("FAIL a_idle_serial: serialOut=%b required 0", a_serial);
            end
            if (a_bits != 0) begin
                miscompares++;
                $display("FAIL a_word_len: enable run ended after %0d bits, required 10", a_bits);
            end
            a_bits = 0;
            a_run  = 0;
        end else begin
            a_run++;
            if (a_run > 10) begin
                miscompares++;
                $display("FAIL a_run_len: enable high %0d cycles, required at most 10", a_run);
            end
            a_word = {a_word[8:0], a_serial};
            a_bits++;
            if (a_bits == 10) begin
                a_bits = 0;
                vectors++;
                if (exp_a.size() == 0) begin
                    miscompares++;
                    $display("FAIL a_unexpected_word: got %0d, none expected", a_word);
                end else begin
                    logic [9:0] e;
                    e = exp_a.pop_front();
                    if (!word_ok(a_word, e)) begin
                        miscompares++;
                        $display("FAIL a_word: got %0d (%b) required %0d", a_word, a_word, e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            b_bits = 0;
        end else if (!b_enable) begin
            vectors++;
            if (b_serial !== 1'b0) begin
                miscompares++;
                $display("FAIL b_idle_serial: serialOut=%b required 0", b_serial);
            end
            if (b_bits != 0) begin
                miscompares++;
                $display("FAIL b_word_len: enable run ended mid-word after %0d bits", b_bits);
            end
            b_bits = 0;
        end else begin
            b_word = {b_word[8:0], b_serial};
            b_bits++;
            if (b_bits == 10) begin
                b_bits = 0;
                vectors++;
                if (exp_b.size() == 0) begin
                    miscompares++;
                    $display("FAIL b_unexpected_word: got %0d, none expected", b_word);
                end else begin
                    logic [9:0] e;
                    e = exp_b.pop_front();
                    if (!word_ok(b_word, e)) begin
                        miscompares++;
                        $display("FAIL b_word: got %0d (%b) required %0d", b_word, b_word, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic push_a(input logic [1:0] t);
        int guard = 0;
        @(negedge clk);
        a_valid = 1'b1;
        a_type  = t;
        while (!a_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            miscompares++;
            $display("FAIL a_push_timeout: coin_ready=%b required 1 within 100 cycles", a_ready);
        end
        @(posedge clk);
        exp_a.push_back(exp_code(t));
        #1;
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [1:0] t);
        int guard = 0;
        @(negedge clk);
        b_valid = 1'b1;
        b_type  = t;
        while (!b_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            miscompares++;
            $display("FAIL b_push_timeout: coin_ready=%b required 1 within 100 cycles", b_ready);
        end
        @(posedge clk);
        exp_b.push_back(exp_code(t));
        #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int max_cycles);
        int n = 0;
        while ((a_busy || exp_a.size() != 0) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n >= max_cycles) begin
            miscompares++;
            $display("FAIL a_drain_timeout: busy=%b pending=%0d after %0d cycles, required idle",
                     a_busy, exp_a.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if (a_enable !== 1'b0 || a_serial !== 1'b0 || a_busy !== 1'b0 ||
            a_coins !== 8'd0 || a_ready !== 1'b1 || a_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_a: en=%b ser=%b busy=%b coins=%0d ready=%b st=%0d required 0 0 0 0 1 0",
                     a_enable, a_serial, a_busy, a_coins, a_ready, a_state);
        end
        vectors++;
        if (b_enable !== 1'b0 || b_busy !== 1'b0 || b_coins !== 8'd0 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_b: en=%b busy=%b coins=%0d ready=%b required 0 0 0 1",
                     b_enable, b_busy, b_coins, b_ready);
        end
    endtask

    task automatic test_single_dime();
        logic hi[12];
        int   n_hi = 0;
        do_reset();
        push_a(2'd2);
        vectors++;
        if (a_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL dime_accept_edge: enable=%b required 0", a_enable);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            hi[i] = a_enable;
            if (a_enable) n_hi++;
            if (i == 0) begin
                vectors++;
                if (a_enable !== 1'b1 || a_serial !== 1'b1) begin
                    miscompares++;
                    $display("FAIL dime_first_bit: enable=%b bit9=%b required 1 1", a_enable, a_serial);
                end
            end
        end
        vectors++;
        if (n_hi != 10 || hi[9] !== 1'b1 || hi[10] !== 1'b0) begin
            miscompares++;
            $display("FAIL dime_enable_len: high=%0d last=%b after=%b required 10 1 0", n_hi, hi[9], hi[10]);
        end
        vectors++;
        if (a_coins !== 8'd1) begin
            miscompares++;
            $display("FAIL dime_coins: coins_sent=%0d required 1", a_coins);
        end
        wait_idle_a(20);
        vectors++;
        if (a_busy !== 1'b0 || a_state !== 2'd0) begin
            miscompares++;
            $display("FAIL dime_idle: busy=%b state=%0d required 0 0", a_busy, a_state);
        end
    endtask

    task automatic test_back_to_back();
        logic prev = 1'b0;
        int   low_len = 0, rises = 0, n = 0;
        do_reset();
        for (int i = 0; i < 5; i++) push_a(2'd3);
        @(negedge clk);
        vectors++;
        if (a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_full: coin_ready=%b required 0", a_ready);
        end
        // The first word is already on the line; count it as seen.
        rises = 1;
        prev  = 1'b1;
        while (!(a_coins == 8'd5 && !a_busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (a_enable) begin
                if (!prev) begin
                    rises++;
                    vectors++;
                    if (low_len != 1) begin
                        miscompares++;
                        $display("FAIL b2b_gap: enable low %0d cycles, required 1", low_len);
                    end
                end
                low_len = 0;
            end else begin
                low_len++;
            end
            prev = a_enable;
        end
        vectors++;
        if (rises != 5 || a_coins !== 8'd5 || exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: words=%0d coins_sent=%0d pending=%0d required 5 5 0",
                     rises, a_coins, exp_a.size());
        end
    endtask

    task automatic test_no_gap();
        int n = 0, run = 0;
        do_reset();
        push_b(2'd0);
        push_b(2'd1);
        while (!b_enable && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (b_enable && run < 40) begin
            run++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (run != 20) begin
            miscompares++;
            $display("FAIL nogap_run: enable high %0d cycles, required 20", run);
        end
        vectors++;
        if (b_coins !== 8'd2 || b_busy !== 1'b0 || exp_b.size() != 0) begin
            miscompares++;
            $display("FAIL nogap_count: coins_sent=%0d busy=%b pending=%0d required 2 0 0",
                     b_coins, b_busy, exp_b.size());
        end
    endtask

    task automatic test_reset_mid_word();
        int n = 0, seen_en = 0;
        do_reset();
        push_a(2'd3);
        push_a(2'd3);
        push_a(2'd3);
        while (!a_enable && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        // enable rose; bit 9 visible. Step to bit 5 and assert reset there.
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (a_enable !== 1'b0 || a_serial !== 1'b0 || a_coins !== 8'd0 ||
            a_busy !== 1'b0 || a_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset: en=%b ser=%b coins=%0d busy=%b ready=%b required 0 0 0 0 1",
                     a_enable, a_serial, a_coins, a_busy, a_ready);
        end
        reset = 1'b0;
        exp_a.delete();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (a_enable || a_busy) seen_en++;
        end
        vectors++;
        if (seen_en != 0 || a_coins !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_flush: active cycles=%0d coins=%0d required 0 0", seen_en, a_coins);
        end
    endtask

    task automatic test_same_edge_push_pop();
        do_reset();
        push_a(2'd0);
        push_a(2'd1);
        push_a(2'd2);
        push_a(2'd3);
        // Three entries wait; the next pop is on the 12th edge after the first push.
        repeat (8) @(posedge clk);
        push_a(2'd1);
        vectors++;
        if (a_ready !== 1'b1 || a_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL pushpop_level: ready=%b enable=%b required 1 1", a_ready, a_enable);
        end
        wait_idle_a(100);
        vectors++;
        if (a_coins !== 8'd5) begin
            miscompares++;
            $display("FAIL pushpop_coins: coins_sent=%0d required 5", a_coins);
        end
    endtask

    task automatic test_wrap_256();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push_a(2'($urandom_range(0, 3)));
            if (i == 0) begin
                vectors++;
                if (a_busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_busy: busy=%b required 1", a_busy);
                end
            end
        end
        wait_idle_a(4000);
        vectors++;
        if (a_coins !== 8'd0 || exp_a.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_coins: coins_sent=%0d pending=%0d required 0 0", a_coins, exp_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_dime();
        test_back_to_back();
        test_no_gap();
        test_reset_mid_word();
        test_same_edge_push_pop();
        test_wrap_256();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
